pipelined_decode_unit: RTL and testbench
========================================

Name: pipelined_decode_unit

Overview:
- Next-generation decode stage for the 16-bit ISA: decodes one instruction per cycle into a registered ID/EX bundle.
- Adds a valid/ready handshake on both sides, pipeline flush, load-use hazard stalling, a sticky halt, and a stall counter.
- Immediates are generalised to a parameterised datapath width.
- Sits between the fetch stage (upstream) and the execute stage (downstream).

Parameters:
- DATA_W, 16: datapath width; width of pc and imm outputs; must be >= 16.
- HAZARD_EN, 1: 1 = load-use stall logic active; 0 = stall logic removed and stall_count held at 0.
- CNT_W, 16: stall_count width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  16  instruction word.
- in_pc  in  DATA_W  PC+2 of in_instr.
- flush  in  1  branch taken in EX; kill pending work.
- out_valid  out  1  ID/EX bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  DATA_W  registered PC+2.
- out_rd, out_rs, out_rt  out  4 each  register specifiers.
- out_imm  out  DATA_W  extended immediate.
- out_alu_op  out  4  ALU operation code.
- out_alu_src1  out  1  0 = rs, 1 = PC+2.
- out_alu_src2  out  1  0 = rt, 1 = imm.
- out_mem_read_en, out_mem_write_en  out  1 each  memory read/write enables.
- out_reg_write_en, out_reg_write_src  out  1 each  register write enable; write source 0 = ALU, 1 = MEM.
- out_branch  out  1  branch instruction.
- out_branch_cond  out  3  instr[11:9].
- out_halt  out  1  bundle is HLT.
- halted  out  1  sticky; HLT has been accepted.
- stall_count  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset, asynchronous: out_valid=0, halted=0, stall_count=0. All other registered outputs reset to 0 (never X).
- Decode table, opcode -> alu_op / src1 / src2 / control:
  - ADD 0/0/0, SUB 1/0/0, XOR 2/0/0, RED 8/0/0, PADDSB 9/0/0: reg_write_en=1, reg_write_src=0.
  - SLL 4, SRA 5, ROR 6 with src1=0, src2=1: reg_write_en=1, reg_write_src=0.
  - LW: alu_op 10, src1=0, src2=1, mem_read_en=1, reg_write_en=1, reg_write_src=1.
  - SW: alu_op 10, src1=0, src2=1, rt=instr[11:8], mem_write_en=1, mem_read_en=0.
  - LLB 11 / LHB 12: src1=0, src2=1, rs=instr[11:8], reg_write_en=1, reg_write_src=0.
  - B: alu_op 10, src1=1, src2=1, branch=1.
  - BR: alu_op 13, src1=0, branch=1.
  - PCS: alu_op 13, src1=1, reg_write_en=1, reg_write_src=0.
  - HLT: halt=1.
  - Unused control fields are driven 0.
- Immediate rules, all extended to DATA_W:
  - Default: sign-extend instr[3:0].
  - LW/SW: sign-extend {instr[3:0],1'b0}.
  - LLB/LHB: zero-extend instr[7:0].
  - B: sign-extend {instr[8:0],1'b0}.
- Output register load: load_en = !out_valid | out_ready. Latency is 1 cycle from acceptance to out_valid.
- Source usage, used for hazard checks only:
  - rs and rt: ADD, SUB, XOR, RED, PADDSB, SW.
  - rs only: SLL, SRA, ROR, LW, LLB, LHB, BR.
  - none: B, PCS, HLT.
- Load-use hazard, when HAZARD_EN=1:
  - hazard = out_valid & out_mem_read_en & in_valid & (out_rd matches a used source of in_instr).
  - On hazard with load_en: load a bubble (out_valid<=0), in_ready=0, stall_count+1 (saturating at all-ones).
  - The held instruction is accepted the following cycle, since the bubble removes the hazard.
- in_ready = load_en & !hazard & !halted, except during flush (below).
- Flush has priority over everything:
  - Next cycle out_valid=0.
  - in_ready=1 that cycle and the fetched instruction is discarded.
  - No stall_count increment.
  - halted is not cleared.
- Halt:
  - Accepting HLT sets halted on the same edge that loads the bundle (out_halt=1).
  - After that, in_ready stays 0 until reset.
  - Flush in the same cycle as the HLT acceptance discards it, and halted stays 0.
- Backpressure: while out_valid & !out_ready, all outputs hold stable and in_ready=0.
- Reset mid-stall or mid-halt: everything returns to reset state immediately.

Test Plan:
- Stream ADD r1,r2,r3 (0x0123) then SUB (0x1456), out_ready=1 -> out_valid one cycle after each accept; alu_op 0 then 1; rd/rs/rt = 1/2/3 then 4/5/6.
- LW r1,r2,-1 (0x812F) then ADD r3,r1,r4 (0x0314) -> one bubble cycle (out_valid=0, in_ready=0); ADD issues the next cycle; stall_count=1; LW imm = 0xFFFE.
- Same pair with ADD r3,r5,r4 (0x0354) -> no bubble; stall_count stays 0. With HAZARD_EN=0 and 0x0314 -> no bubble.
- B cond=3, offset -2 (0xC7FE) -> out_imm=0xFFFC, branch=1, branch_cond=3. LLB r2,0xAB (0xA2AB) -> imm=0x00AB, rs=2.
- out_ready=0 for 3 cycles with a valid bundle -> outputs stable, in_ready=0. Then assert flush -> out_valid=0 next cycle and the presented instruction is dropped.
- Accept HLT (0xF000) -> out_halt=1, halted=1, in_ready=0 thereafter. Assert rst mid-run -> halted=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipelined_decode_unit.sv
// rtl/pipelined_decode_unit.sv - ID stage for the 16-bit ISA with handshakes, flush, load-use stall and halt
//
// Decodes one instruction per cycle into a registered ID/EX bundle.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         fetch handshake; in_instr word, in_pc is PC+2 of in_instr
//   flush                     branch taken in EX: kill the bundle and discard the fetched word
//   out_valid/out_ready       execute handshake for the ID/EX bundle
//   out_pc .. out_halt        registered decoded fields of the bundle
//   halted                    sticky, set when HLT is accepted
//   stall_count               saturating count of load-use bubbles
module pipelined_decode_unit #(
    parameter int DATA_W    = 16,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_rs,
    output logic [3:0]        out_rt,
    output logic [DATA_W-1:0] out_imm,
    output logic [3:0]        out_alu_op,
    output logic              out_alu_src1,
    output logic              out_alu_src2,
    output logic              out_mem_read_en,
    output logic              out_mem_write_en,
    output logic              out_reg_write_en,
    output logic              out_reg_write_src,
    output logic              out_branch,
    output logic [2:0]        out_branch_cond,
    output logic              out_halt,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    logic [3:0]        op;
    logic [3:0]        d_rs, d_rt, d_alu_op;
    logic [DATA_W-1:0] d_imm;
    logic              d_src1, d_src2, d_mr, d_mw, d_rw, d_rws, d_br, d_halt;
    logic              use_rs, use_rt;
    logic              load_en, hazard;

    assign op = in_instr[15:12];

    always_comb begin
        d_rs     = in_instr[7:4];
        d_rt     = in_instr[3:0];
        d_alu_op = 4'd0;
        d_imm    = {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};
        d_src1   = 1'b0;
        d_src2   = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_rw     = 1'b0;
        d_rws    = 1'b0;
        d_br     = 1'b0;
        d_halt   = 1'b0;
        use_rs   = 1'b1;
        use_rt   = 1'b0;
        case (op)
            4'h0: begin d_alu_op = 4'd0; d_rw = 1'b1; use_rt = 1'b1; end  // ADD
            4'h1: begin d_alu_op = 4'd1; d_rw = 1'b1; use_rt = 1'b1; end  // SUB
            4'h2: begin d_alu_op = 4'd2; d_rw = 1'b1; use_rt = 1'b1; end  // XOR
            4'h3: begin d_alu_op = 4'd8; d_rw = 1'b1; use_rt = 1'b1; end  // RED
            4'h4: begin d_alu_op = 4'd4; d_src2 = 1'b1; d_rw = 1'b1; end  // SLL
            4'h5: begin d_alu_op = 4'd5; d_src2 = 1'b1; d_rw = 1'b1; end  // SRA
            4'h6: begin d_alu_op = 4'd6; d_src2 = 1'b1; d_rw = 1'b1; end  // ROR
            4'h7: begin d_alu_op = 4'd9; d_rw = 1'b1; use_rt = 1'b1; end  // PADDSB
            4'h8: begin                                                    // LW
                d_alu_op = 4'd10; d_src2 = 1'b1; d_mr = 1'b1;
                d_rw = 1'b1; d_rws = 1'b1;
                d_imm = {{(DATA_W-5){in_instr[3]}}, in_instr[3:0], 1'b0};
            end
            4'h9: begin                                                    // SW: store data comes from rd field
                d_alu_op = 4'd10; d_src2 = 1'b1; d_mw = 1'b1;
                d_rt = in_instr[11:8]; use_rt = 1'b1;
                d_imm = {{(DATA_W-5){in_instr[3]}}, in_instr[3:0], 1'b0};
            end
            4'hA, 4'hB: begin                                              // LLB/LHB read-modify-write rd
                d_alu_op = (op == 4'hA) ? 4'd11 : 4'd12;
                d_src2 = 1'b1; d_rw = 1'b1;
                d_rs = in_instr[11:8];
                d_imm = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
            end
            4'hC: begin                                                    // B: PC-relative, halfword offset
                d_alu_op = 4'd10; d_src1 = 1'b1; d_src2 = 1'b1; d_br = 1'b1;
                use_rs = 1'b0;
                d_imm = {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};
            end
            4'hD: begin d_alu_op = 4'd13; d_br = 1'b1; end                // BR
            4'hE: begin d_alu_op = 4'd13; d_src1 = 1'b1; d_rw = 1'b1; use_rs = 1'b0; end // PCS
            default: begin d_halt = 1'b1; use_rs = 1'b0; end               // HLT
        endcase
    end

    assign load_en = !out_valid || out_ready;

    // Only a load sitting in the output register can create a load-use hazard;
    // once the bubble is loaded out_valid drops and the hazard clears itself.
    assign hazard = (HAZARD_EN != 0) && out_valid && out_mem_read_en && in_valid &&
                    ((use_rs && (out_rd == d_rs)) || (use_rt && (out_rd == d_rt)));

    // During flush the fetched word is taken and thrown away, so fetch may advance.
    assign in_ready = flush || (load_en && !hazard && !halted);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_pc            <= '0;
            out_rd            <= '0;
            out_rs            <= '0;
            out_rt            <= '0;
            out_imm           <= '0;
            out_alu_op        <= '0;
            out_alu_src1      <= 1'b0;
            out_alu_src2      <= 1'b0;
            out_mem_read_en   <= 1'b0;
            out_mem_write_en  <= 1'b0;
            out_reg_write_en  <= 1'b0;
            out_reg_write_src <= 1'b0;
            out_branch        <= 1'b0;
            out_branch_cond   <= '0;
            out_halt          <= 1'b0;
            halted            <= 1'b0;
            stall_count       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            if (hazard) begin
                out_valid <= 1'b0;
                if (stall_count != {CNT_W{1'b1}})
                    stall_count <= stall_count + CNT_W'(1);
            end else if (in_valid && !halted) begin
                out_valid         <= 1'b1;
                out_pc            <= in_pc;
                out_rd            <= in_instr[11:8];
                out_rs            <= d_rs;
                out_rt            <= d_rt;
                out_imm           <= d_imm;
                out_alu_op        <= d_alu_op;
                out_alu_src1      <= d_src1;
                out_alu_src2      <= d_src2;
                out_mem_read_en   <= d_mr;
                out_mem_write_en  <= d_mw;
                out_reg_write_en  <= d_rw;
                out_reg_write_src <= d_rws;
                out_branch        <= d_br;
                out_branch_cond   <= in_instr[11:9];
                out_halt          <= d_halt;
                if (d_halt)
                    halted <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// tb/tb_pipelined_decode_unit.sv - scoreboard bench for pipelined_decode_unit
module tb_pipelined_decode_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  rd, rs, rt;
        logic [15:0] imm;
        logic [3:0]  alu;
        logic        s1, s2, mr, mw, rw, rws, br;
        logic [2:0]  bc;
        logic        halt;
    } bundle_t;

    // Opcode order: ADD SUB XOR RED SLL SRA ROR PADDSB LW SW LLB LHB B BR PCS HLT
    localparam logic [3:0] ALU_TBL [16] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd4, 4'd5, 4'd6, 4'd9,
                                            4'd10, 4'd10, 4'd11, 4'd12, 4'd10, 4'd13, 4'd13, 4'd0};
    localparam logic [15:0] SRC1_M = 16'h5000;  // B, PCS
    localparam logic [15:0] SRC2_M = 16'h1F70;  // SLL SRA ROR LW SW LLB LHB B
    localparam logic [15:0] RW_M   = 16'h4DFF;  // everything writing a register
    localparam logic [15:0] BR_M   = 16'h3000;  // B, BR
    localparam logic [15:0] RS_M   = 16'h2FFF;  // reads rs
    localparam logic [15:0] RT_M   = 16'h028F;  // reads rt

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_rd, out_rs, out_rt, out_alu_op;
    logic        out_alu_src1, out_alu_src2, out_mem_read_en, out_mem_write_en;
    logic        out_reg_write_en, out_reg_write_src, out_branch, out_halt, halted;
    logic [2:0]  out_branch_cond;
    logic [15:0] stall_count;

    logic        n_in_ready, n_out_valid;
    logic [15:0] n_out_pc, n_out_imm, n_stall_count;
    logic [3:0]  n_out_rd, n_out_rs, n_out_rt, n_out_alu_op;
    logic        n_s1, n_s2, n_mr, n_mw, n_rw, n_rws, n_br, n_halt, n_halted;
    logic [2:0]  n_bc;

    always #5 clk = ~clk;

    pipelined_decode_unit #(.DATA_W(16), .HAZARD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
        .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
        .out_reg_write_en(out_reg_write_en), .out_reg_write_src(out_reg_write_src),
        .out_branch(out_branch), .out_branch_cond(out_branch_cond), .out_halt(out_halt),
        .halted(halted), .stall_count(stall_count)
    );

    // Hazard-free variant shares the fetch side, always ready downstream, never flushed.
    pipelined_decode_unit #(.DATA_W(16), .HAZARD_EN(0), .CNT_W(16)) dut_nh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(1'b0), .out_valid(n_out_valid), .out_ready(1'b1),
        .out_pc(n_out_pc), .out_rd(n_out_rd), .out_rs(n_out_rs), .out_rt(n_out_rt), .out_imm(n_out_imm),
        .out_alu_op(n_out_alu_op), .out_alu_src1(n_s1), .out_alu_src2(n_s2),
        .out_mem_read_en(n_mr), .out_mem_write_en(n_mw),
        .out_reg_write_en(n_rw), .out_reg_write_src(n_rws),
        .out_branch(n_br), .out_branch_cond(n_bc), .out_halt(n_halt),
        .halted(n_halted), .stall_count(n_stall_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bundle_t exp_q[$];

    // Reference model state
    logic        m_valid, m_load, m_halted;
    logic [3:0]  m_rd;
    logic [15:0] m_stall;
    logic [15:0] pc_ctr;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t ref_decode(input logic [15:0] ins, input logic [15:0] pc);
        bundle_t b;
        int op;
        int v;
        op = int'(ins[15:12]);
        b.pc = pc;
        b.rd = ins[11:8];
        b.rs = (op == 10 || op == 11) ? ins[11:8] : ins[7:4];
        b.rt = (op == 9) ? ins[11:8] : ins[3:0];
        b.alu = ALU_TBL[op];
        b.s1 = SRC1_M[op];
        b.s2 = SRC2_M[op];
        b.mr = (op == 8);
        b.mw = (op == 9);
        b.rw = RW_M[op];
        b.rws = (op == 8);
        b.br = BR_M[op];
        b.bc = ins[11:9];
        b.halt = (op == 15);
        if (op == 8 || op == 9)       v = int'($signed(ins[3:0])) * 2;
        else if (op == 10 || op == 11) v = int'(ins[7:0]);
        else if (op == 12)             v = int'($signed(ins[8:0])) * 2;
        else                           v = int'($signed(ins[3:0]));
        b.imm = 16'(v);
        return b;
    endfunction

    function automatic logic reads_reg(input logic [15:0] ins, input logic [3:0] r);
        bundle_t b;
        int op;
        b = ref_decode(ins, 16'h0);
        op = int'(ins[15:12]);
        return (RS_M[op] && b.rs == r) || (RT_M[op] && b.rt == r);
    endfunction

    // Monitor: whenever a bundle is presented, it must match the oldest expectation;
    // it is retired when execute takes it.
    initial begin
        bundle_t act;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                act = '{out_pc, out_rd, out_rs, out_rt, out_imm, out_alu_op, out_alu_src1,
                        out_alu_src2, out_mem_read_en, out_mem_write_en, out_reg_write_en,
                        out_reg_write_src, out_branch, out_branch_cond, out_halt};
                if (exp_q.size() == 0) begin
                    chk("unexpected_bundle", {80'h0, act[63:48]}, 96'h0);
                end else begin
                    chk("bundle", {16'h0, act}, {16'h0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        m_valid = 1'b0; m_load = 1'b0; m_halted = 1'b0; m_rd = 4'h0; m_stall = 16'h0;
        exp_q.delete();
    endtask

    // One clock of stimulus: drive, check pre-edge status, then advance the model past the edge.
    task automatic cycle(input logic iv, input logic [15:0] ins, input logic fl, input logic ordy);
        logic le, hz, er;
        in_valid = iv; in_instr = ins; in_pc = pc_ctr; flush = fl; out_ready = ordy;
        le = !m_valid || ordy;
        hz = m_valid && m_load && iv && reads_reg(ins, m_rd);
        er = fl || (le && !hz && !m_halted);
        #1;
        chk("in_ready", {95'h0, in_ready}, {95'h0, er});
        chk("out_valid", {95'h0, out_valid}, {95'h0, m_valid});
        chk("halted", {95'h0, halted}, {95'h0, m_halted});
        chk("stall_count", {80'h0, stall_count}, {80'h0, m_stall});
        @(posedge clk);
        #1;
        if (fl) begin
            m_valid = 1'b0;
            exp_q.delete();
        end else if (le) begin
            if (hz) begin
                m_valid = 1'b0;
                if (m_stall != 16'hFFFF) m_stall = m_stall + 16'h1;
            end else if (iv && er) begin
                m_valid = 1'b1;
                m_load = (ins[15:12] == 4'h8);
                m_rd = ins[11:8];
                if (ins[15:12] == 4'hF) m_halted = 1'b1;
                exp_q.push_back(ref_decode(ins, pc_ctr));
            end else begin
                m_valid = 1'b0;
            end
        end
        pc_ctr = pc_ctr + 16'h2;
    endtask

    initial begin
        logic [15:0] ins;
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0; flush = 1'b0; out_ready = 1'b0;
        pc_ctr = 16'h0100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {95'h0, out_valid}, 96'h0);
        chk("rst_halted", {95'h0, halted}, 96'h0);
        chk("rst_stall", {80'h0, stall_count}, 96'h0);
        chk("rst_imm", {80'h0, out_imm}, 96'h0);
        rst = 1'b0;

        // ADD then SUB streaming
        cycle(1, 16'h0123, 0, 1);
        chk("add_rs", {92'h0, out_rs}, 96'h2);
        cycle(1, 16'h1456, 0, 1);
        chk("sub_alu", {92'h0, out_alu_op}, 96'h1);
        cycle(0, 16'h0, 0, 1);

        // LW then dependent ADD: one bubble; the hazard-free instance never bubbles
        cycle(1, 16'h812F, 0, 1);
        chk("lw_imm", {80'h0, out_imm}, 96'hFFFE);
        cycle(1, 16'h0314, 0, 1);
        chk("bubble_valid", {95'h0, out_valid}, 96'h0);
        chk("nh_issued", {95'h0, n_out_valid}, 96'h1);
        chk("nh_rs", {92'h0, n_out_rs}, 96'h1);
        chk("nh_stall", {80'h0, n_stall_count}, 96'h0);
        cycle(1, 16'h0314, 0, 1);
        chk("stall_one", {80'h0, stall_count}, 96'h1);

        // Independent follower: no bubble
        cycle(1, 16'h812F, 0, 1);
        cycle(1, 16'h0354, 0, 1);
        chk("no_stall", {80'h0, stall_count}, 96'h1);

        // Branch and LLB immediates
        cycle(1, 16'hC7FE, 0, 1);
        chk("b_imm", {80'h0, out_imm}, 96'hFFFC);
        chk("b_branch", {95'h0, out_branch}, 96'h1);
        chk("b_cond", {93'h0, out_branch_cond}, 96'h3);
        cycle(1, 16'hA2AB, 0, 1);
        chk("llb_imm", {80'h0, out_imm}, 96'h00AB);
        chk("llb_rs", {92'h0, out_rs}, 96'h2);

        // Backpressure for 3 cycles, then flush drops the presented word
        cycle(1, 16'h2789, 0, 1);
        repeat (3) cycle(1, 16'h0111, 0, 0);
        cycle(1, 16'h0222, 1, 0);
        chk("flush_valid", {95'h0, out_valid}, 96'h0);
        cycle(0, 16'h0, 0, 1);

        // HLT killed by same-cycle flush
        cycle(1, 16'hF000, 1, 1);
        chk("hlt_flushed", {95'h0, halted}, 96'h0);

        // Random traffic (no HLT)
        for (int i = 0; i < 400; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                ins = {ins[15:12], 2'b00, ins[9:8], 2'b00, ins[5:4], ins[3:0]};
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h8;
            cycle($urandom_range(0, 9) < 8, ins, $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
        end
        cycle(0, 16'h0, 0, 1);

        // Halt is sticky
        cycle(1, 16'hF000, 0, 1);
        chk("hlt_out_halt", {95'h0, out_halt}, 96'h1);
        chk("hlt_halted", {95'h0, halted}, 96'h1);
        for (int i = 0; i < 6; i++)
            cycle(1, 16'($urandom) & 16'h7FFF, i == 3, $urandom_range(0, 1) == 1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {95'h0, out_valid}, 96'h0);
        chk("arst_halted", {95'h0, halted}, 96'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 16'h0123, 0, 1);
        cycle(0, 16'h0, 0, 1);
        cycle(0, 16'h0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
